// File: rtl/ram_refresh_pkg.sv
// Shared definitions for the CAS-before-RAS refresh engine and the RAM controller.
// Holds the refresh state encoding, the timing defaults and a saturating-increment helper.
package ram_refresh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_CAS  = 3'd2,
    ST_RAS  = 3'd3,
    ST_PRE  = 3'd4
  } ref_state_e;

  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0] TCSR_DEF = 4'd1;
  localparam logic [CNT_W-1:0] TRAS_DEF = 4'd4;
  localparam logic [CNT_W-1:0] TRP_DEF  = 4'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_refresh_timer.sv
// Loadable 4-bit down-counter that times each refresh phase.
// tc_o marks the last cycle of a phase, i.e. the cycle on which the count is 1.
module ram_refresh_timer
  import ram_refresh_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ram_refresh.sv
// CAS-before-RAS refresh engine: owes one refresh per timer period and runs it while the bus
// is idle, or stalls new RAM accesses once the timer flags the refresh as urgent.
module ram_refresh
  import ram_refresh_pkg::*;
#(
  parameter logic [CNT_W-1:0] TCSR = TCSR_DEF,
  parameter logic [CNT_W-1:0] TRAS = TRAS_DEF,
  parameter logic [CNT_W-1:0] TRP  = TRP_DEF
) (
  input  logic             CLK,
  input  logic             nRESin,
  input  logic             RefReq,
  input  logic             RefUrg,
  input  logic             BACT,
  input  logic             RAMBusy,
  output logic             RAMHold,
  output logic             RefOwn,
  output logic             RefRAS,
  output logic             RefCAS,
  output logic             RefDone,
  output logic [CNT_W-1:0] MissCnt,
  output ref_state_e       dbg_state_o,
  output logic             dbg_pending_o
);

  ref_state_e       state_q;
  logic             pending_q;
  logic             ref_req_q;
  logic [CNT_W-1:0] miss_q;
  logic             hold_q, own_q, ras_q, cas_q, done_q;

  logic             tc;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             rise, fall, start_w, abort_w, go_cas, pre_exit;

  assign rise     = RefReq && !ref_req_q;
  assign fall     = !RefReq && ref_req_q;
  assign start_w  = pending_q && (!BACT || RefUrg);
  assign abort_w  = (state_q == ST_HOLD) && !RefUrg && BACT;
  // hold_q being set in HOLD means the controller has already seen RAMHold for a full cycle.
  assign go_cas   = (state_q == ST_HOLD) && !abort_w && !RAMBusy && hold_q;
  assign pre_exit = (state_q == ST_PRE) && tc;

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (go_cas) begin
      cnt_load = 1'b1;
      cnt_val  = TCSR;
    end else if (state_q == ST_CAS && tc) begin
      cnt_load = 1'b1;
      cnt_val  = TRAS;
    end else if (state_q == ST_RAS && tc) begin
      cnt_load = 1'b1;
      cnt_val  = TRP;
    end
  end

  ram_refresh_timer u_timer (
    .clk_i      (CLK),
    .rst_ni     (nRESin),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (tc)
  );

  always_ff @(posedge CLK) begin
    if (!nRESin) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      ref_req_q <= 1'b0;
      miss_q    <= '0;
      hold_q    <= 1'b0;
      own_q     <= 1'b0;
      ras_q     <= 1'b0;
      cas_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ref_req_q <= RefReq;
      done_q    <= 1'b0;

      // A boundary that lands mid-sequence is not a miss: that refresh is about to complete.
      if (fall && pending_q && (state_q == ST_IDLE || state_q == ST_HOLD)) begin
        miss_q <= sat_inc(miss_q);
      end

      if (rise) begin
        pending_q <= 1'b1;
      end else if (pre_exit) begin
        pending_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_w) begin
            state_q <= ST_HOLD;
            hold_q  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (abort_w) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
          end else if (go_cas) begin
            state_q <= ST_CAS;
            own_q   <= 1'b1;
            cas_q   <= 1'b1;
          end
        end
        ST_CAS: begin
          if (tc) begin
            state_q <= ST_RAS;
            ras_q   <= 1'b1;
          end
        end
        ST_RAS: begin
          if (tc) begin
            state_q <= ST_PRE;
            ras_q   <= 1'b0;
            cas_q   <= 1'b0;
          end
        end
        ST_PRE: begin
          if (tc) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
            own_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hold_q  <= 1'b0;
          own_q   <= 1'b0;
          ras_q   <= 1'b0;
          cas_q   <= 1'b0;
        end
      endcase
    end
  end

  assign RAMHold       = hold_q;
  assign RefOwn        = own_q;
  assign RefRAS        = ras_q;
  assign RefCAS        = cas_q;
  assign RefDone       = done_q;
  assign MissCnt       = miss_q;
  assign dbg_state_o   = state_q;
  assign dbg_pending_o = pending_q;

endmodule

// File: tb/tb_ram_refresh.sv
// Directed bench for ram_refresh with the default timing (TCSR=1, TRAS=4, TRP=2).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_ram_refresh;
  import ram_refresh_pkg::*;

  logic       CLK;
  logic       nRESin;
  logic       RefReq, RefUrg, BACT, RAMBusy;
  logic       RAMHold, RefOwn, RefRAS, RefCAS, RefDone;
  logic [3:0] MissCnt;
  ref_state_e dbg_state;
  logic       dbg_pending;

  int checks;
  int errors;

  // Packed view {RAMHold, RefOwn, RefRAS, RefCAS, RefDone}
  logic [4:0] outs;
  assign outs = {RAMHold, RefOwn, RefRAS, RefCAS, RefDone};

  // Cycle-by-cycle outputs after a rise with the bus idle: 1 idle, 1 HOLD, 1 CAS, 4 RAS, 2 PRE, done, idle
  logic [4:0] seq_ref [0:10];

  ram_refresh dut (
    .CLK           (CLK),
    .nRESin        (nRESin),
    .RefReq        (RefReq),
    .RefUrg        (RefUrg),
    .BACT          (BACT),
    .RAMBusy       (RAMBusy),
    .RAMHold       (RAMHold),
    .RefOwn        (RefOwn),
    .RefRAS        (RefRAS),
    .RefCAS        (RefCAS),
    .RefDone       (RefDone),
    .MissCnt       (MissCnt),
    .dbg_state_o   (dbg_state),
    .dbg_pending_o (dbg_pending)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRESin = 1'b0; RefReq = 1'b0; RefUrg = 1'b0; BACT = 1'b0; RAMBusy = 1'b0;
    tick();
    tick();
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL reset_outs: got %b expected %b", outs, 5'b00000);
    end
    checks++;
    if (MissCnt !== 4'd0) begin
      errors++; $display("FAIL reset_miss: got %0d expected 0", MissCnt);
    end
    checks++;
    if (dbg_state !== ST_IDLE || dbg_pending !== 1'b0) begin
      errors++; $display("FAIL reset_state: got state=%0d pending=%b expected 0/0", dbg_state, dbg_pending);
    end
    nRESin = 1'b1;
    tick();
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL reset_release: got %b expected %b", outs, 5'b00000);
    end
  endtask

  task automatic test_opportunistic();
    BACT = 1'b0; RAMBusy = 1'b0; RefUrg = 1'b0;
    RefReq = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      tick();
      checks++;
      if (outs !== seq_ref[i]) begin
        errors++; $display("FAIL opp_seq[%0d]: got %b expected %b", i, outs, seq_ref[i]);
      end
      if (i == 0) begin
        checks++;
        if (dbg_pending !== 1'b1) begin
          errors++; $display("FAIL opp_pending_set: got %b expected 1", dbg_pending);
        end
      end
      if (i == 9) begin
        checks++;
        if (dbg_pending !== 1'b0) begin
          errors++; $display("FAIL opp_pending_clr: got %b expected 0", dbg_pending);
        end
      end
    end
    checks++;
    if (MissCnt !== 4'd0) begin
      errors++; $display("FAIL opp_miss: got %0d expected 0", MissCnt);
    end
  endtask

  task automatic test_urgent();
    bit seen;
    BACT = 1'b1; RAMBusy = 1'b1; RefUrg = 1'b0;
    RefReq = 1'b0;
    tick();
    RefReq = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (outs !== 5'b00000) begin
        errors++; $display("FAIL urg_wait[%0d]: got %b expected %b", i, outs, 5'b00000);
      end
    end
    RefUrg = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (outs !== 5'b10000) begin
        errors++; $display("FAIL urg_stall[%0d]: got %b expected %b", i, outs, 5'b10000);
      end
    end
    RAMBusy = 1'b0;
    tick();
    checks++;
    if (outs !== 5'b11010) begin
      errors++; $display("FAIL urg_cas: got %b expected %b", outs, 5'b11010);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (RefDone === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL urg_done: got no RefDone within 20 cycles expected one");
    end
    RefUrg = 1'b0;
  endtask

  task automatic test_abort();
    bit seen;
    BACT = 1'b1; RefUrg = 1'b0; RAMBusy = 1'b0;
    RefReq = 1'b0;
    tick();
    RefReq = 1'b1;
    tick();
    tick();
    checks++;
    if (outs !== 5'b00000 || dbg_pending !== 1'b1) begin
      errors++; $display("FAIL abort_owed: got outs=%b pending=%b expected 00000/1", outs, dbg_pending);
    end
    BACT = 1'b0;
    tick();
    checks++;
    if (outs !== 5'b10000) begin
      errors++; $display("FAIL abort_hold: got %b expected %b", outs, 5'b10000);
    end
    BACT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs !== 5'b00000 || dbg_pending !== 1'b1) begin
        errors++; $display("FAIL abort_drop[%0d]: got outs=%b pending=%b expected 00000/1", i, outs, dbg_pending);
      end
    end
    BACT = 1'b0;
    tick();
    tick();
    checks++;
    if (outs !== 5'b11010) begin
      errors++; $display("FAIL abort_resume_cas: got %b expected %b", outs, 5'b11010);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (RefDone === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || dbg_pending !== 1'b0) begin
      errors++; $display("FAIL abort_done: got done_seen=%b pending=%b expected 1/0", seen, dbg_pending);
    end
  endtask

  task automatic one_period();
    RefReq = 1'b0;
    tick();
    RefReq = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_miss_count();
    int exp_miss;
    BACT = 1'b1; RefUrg = 1'b0; RAMBusy = 1'b0;
    // First boundary ends a period with nothing owed; the next three each end owed.
    for (int i = 0; i < 4; i++) one_period();
    checks++;
    if (MissCnt !== 4'd3) begin
      errors++; $display("FAIL miss_three: got %0d expected 3", MissCnt);
    end
    for (int i = 1; i <= 17; i++) begin
      one_period();
      exp_miss = (3 + i > 15) ? 15 : 3 + i;
      checks++;
      if (MissCnt !== exp_miss[3:0]) begin
        errors++; $display("FAIL miss_sat[%0d]: got %0d expected %0d", i, MissCnt, exp_miss);
      end
    end
  endtask

  task automatic test_reset_in_ras();
    BACT = 1'b0; RefUrg = 1'b0; RAMBusy = 1'b0;
    tick();
    checks++;
    if (outs !== 5'b10000) begin
      errors++; $display("FAIL rst_ras_hold: got %b expected %b", outs, 5'b10000);
    end
    tick();
    tick();
    tick();
    checks++;
    if (outs !== 5'b11110) begin
      errors++; $display("FAIL rst_ras_second: got %b expected %b", outs, 5'b11110);
    end
    nRESin = 1'b0;
    RefReq = 1'b0;
    tick();
    checks++;
    if (outs !== 5'b00000 || MissCnt !== 4'd0) begin
      errors++; $display("FAIL rst_ras_edge: got outs=%b miss=%0d expected 00000/0", outs, MissCnt);
    end
    nRESin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (outs !== 5'b00000) begin
        errors++; $display("FAIL rst_ras_quiet[%0d]: got %b expected %b", i, outs, 5'b00000);
      end
    end
  endtask

  task automatic test_boundary_in_refresh();
    BACT = 1'b0; RefUrg = 1'b0; RAMBusy = 1'b0;
    RefReq = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      tick();
      checks++;
      if (outs !== seq_ref[i]) begin
        errors++; $display("FAIL bnd_seq[%0d]: got %b expected %b", i, outs, seq_ref[i]);
      end
      if (i == 3) RefReq = 1'b0;
      if (i == 8) RefReq = 1'b1;
      if (i == 4) begin
        checks++;
        if (MissCnt !== 4'd0) begin
          errors++; $display("FAIL bnd_no_miss: got %0d expected 0", MissCnt);
        end
      end
    end
    checks++;
    if (dbg_pending !== 1'b1 || MissCnt !== 4'd0) begin
      errors++; $display("FAIL bnd_set_wins: got pending=%b miss=%0d expected 1/0", dbg_pending, MissCnt);
    end
    BACT = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    seq_ref[0]  = 5'b00000;
    seq_ref[1]  = 5'b10000;
    seq_ref[2]  = 5'b11010;
    seq_ref[3]  = 5'b11110;
    seq_ref[4]  = 5'b11110;
    seq_ref[5]  = 5'b11110;
    seq_ref[6]  = 5'b11110;
    seq_ref[7]  = 5'b11000;
    seq_ref[8]  = 5'b11000;
    seq_ref[9]  = 5'b00001;
    seq_ref[10] = 5'b00000;

    test_reset();
    test_opportunistic();
    test_urgent();
    test_abort();
    test_miss_count();
    test_reset_in_ras();
    test_boundary_in_refresh();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
